spi_master: RTL

Serial SPI transmitter/receiver that drives the chip-select, serial clock and MOSI lines consumed by the team's `spi_slave` block, and captures MISO in parallel. Sits between a parallel word source (register bank, command FSM) and the SPI pins. It accepts one word per valid/ready handshake, shifts it out MSB-first in the configured SPI mode, and returns the word sampled on MISO during the same frame.

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_clk_gen.sv | 77 +++++++
 rtl/spi_master.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM state encoding and SPI mode constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

    // Frame sequencing of the master; the slave and the bench reuse these names.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    // SPI modes packed as {CPOL, CPHA}.
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic logic mode_cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic logic mode_cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: divides clk into spi_clk half-periods and numbers the edges of one frame.
// Latency: first spi_clk edge is registered CLK_DIV cycles after en rises; pulses coincide with the toggle.
// Backpressure: none; the divider free-runs while en is high and holds at zero otherwise.
//
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   en                run the divider (high only while the master is shifting)
//   clr               restart a frame: edge counter to 0, spi_clk to CPOL
//   spi_clk           registered serial clock
//   lead_pulse        this cycle launches an odd (leading) edge
//   trail_pulse       this cycle launches an even (trailing) edge
//   done              this cycle launches edge 2*BIT_LEN, the last of the frame
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int   BIT_LEN = 8,
    parameter logic CPOL    = 1'b0,
    parameter int   CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic spi_clk,
    output logic lead_pulse,
    output logic trail_pulse,
    output logic done
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int EW = $clog2(2 * BIT_LEN + 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [EW-1:0] edge_cnt_q, edge_cnt_d;
    logic          spi_clk_q, spi_clk_d;
    logic          tc;

    always_comb begin
        tc         = en && (div_cnt_q == DW'(CLK_DIV - 1));
        div_cnt_d  = '0;
        edge_cnt_d = edge_cnt_q;
        spi_clk_d  = spi_clk_q;

        if (en && !tc) begin
            div_cnt_d = div_cnt_q + DW'(1);
        end

        if (clr) begin
            edge_cnt_d = '0;
            spi_clk_d  = CPOL;
        end else if (tc) begin
            edge_cnt_d = edge_cnt_q + EW'(1);
            spi_clk_d  = ~spi_clk_q;
        end

        // edge_cnt_q holds the number of edges already made, so the edge
        // being launched now is odd (leading) when that count is even.
        lead_pulse  = tc && !edge_cnt_q[0];
        trail_pulse = tc &&  edge_cnt_q[0];
        done        = tc && (edge_cnt_q == EW'(2 * BIT_LEN - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            spi_clk_q  <= CPOL;
        end else begin
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            spi_clk_q  <= spi_clk_d;
        end
    end

    assign spi_clk = spi_clk_q;

endmodule

// File: rtl/spi_master.sv
// spi_master: sends one BIT_LEN word per valid/ready handshake MSB-first and returns the MISO word of the same frame.
// Latency: spi_cs falls 1 cycle after accept; rx_data_valid pulses 1+CLK_DIV*(2+2*BIT_LEN) cycles after accept.
// Backpressure: tx_ready is low from accept until CS_GAP cycles after spi_cs rises; tx_data is ignored meanwhile.
//
// Ports:
//   clk, rst                    system clock, asynchronous active-low reset
//   tx_valid, tx_ready, tx_data word handshake toward the block
//   spi_cs, spi_clk, spi_mosi   registered SPI pin outputs
//   spi_miso                    SPI data in, asynchronous to clk edges (synchronised here)
//   rx_data, rx_data_valid      captured word, held until the next frame ends; one-cycle valid pulse
//   busy                        high while a frame (including its CS gap) is in progress
module spi_master
    import spi_pkg::*;
#(
    parameter int   BIT_LEN = 8,
    parameter logic CPOL    = 1'b0,
    parameter logic CPHA    = 1'b1,
    parameter int   CLK_DIV = 4,
    parameter int   CS_GAP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic [BIT_LEN-1:0] tx_data,
    output logic               spi_cs,
    output logic               spi_clk,
    output logic               spi_mosi,
    input  logic               spi_miso,
    output logic [BIT_LEN-1:0] rx_data,
    output logic               rx_data_valid,
    output logic               busy
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = $clog2(CS_GAP + 1);

    spi_state_e         state_q, state_d;
    logic [DW-1:0]      cnt_q, cnt_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [BIT_LEN-1:0] tx_shift_q, tx_shift_d;
    logic [BIT_LEN-1:0] rx_shift_q, rx_shift_d;
    logic [BIT_LEN-1:0] rx_data_q, rx_data_d;
    logic               rx_vld_q, rx_vld_d;
    logic               cs_q, cs_d;
    logic               mosi_q, mosi_d;
    logic               miso_s1_q, miso_s2_q;
    logic [1:0]         samp_q, samp_d;
    logic               accept, launch, sample;
    logic               lead_pulse, trail_pulse, clk_done;

    spi_clk_gen #(
        .BIT_LEN (BIT_LEN),
        .CPOL    (CPOL),
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk         (clk),
        .rst         (rst),
        .en          (state_q == SHIFT),
        .clr         (accept),
        .spi_clk     (spi_clk),
        .lead_pulse  (lead_pulse),
        .trail_pulse (trail_pulse),
        .done        (clk_done)
    );

    always_comb begin
        // CPHA=0 already presented the MSB at accept, so its trailing edges
        // launch the following bits and the final trailing edge launches nothing.
        launch = CPHA ? lead_pulse : (trail_pulse && !clk_done);
        sample = CPHA ? trail_pulse : lead_pulse;

        accept     = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_vld_d   = 1'b0;
        cs_d       = cs_q;
        mosi_d     = mosi_q;

        // MISO is taken from the synchroniser two cycles after the sampling
        // edge, i.e. the pin value present in the edge cycle itself.
        samp_d = {samp_q[0], sample};
        if (samp_q[1]) begin
            rx_shift_d = {rx_shift_q[BIT_LEN-2:0], miso_s2_q};
        end

        if (launch) begin
            mosi_d     = CPHA ? tx_shift_q[BIT_LEN-1] : tx_shift_q[BIT_LEN-2];
            tx_shift_d = tx_shift_q << 1;
        end

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    accept     = 1'b1;
                    tx_shift_d = tx_data;
                    cs_d       = 1'b0;
                    cnt_d      = '0;
                    if (!CPHA) begin
                        mosi_d = tx_data[BIT_LEN-1];
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == DW'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            SHIFT: begin
                if (clk_done) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == DW'(CLK_DIV - 1)) begin
                    cs_d      = 1'b1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_shift_q;
                    rx_vld_d  = 1'b1;
                    gap_d     = '0;
                    state_d   = GAP;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            GAP: begin
                if (gap_q == GW'(CS_GAP - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gap_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_vld_q   <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            miso_s1_q  <= 1'b0;
            miso_s2_q  <= 1'b0;
            samp_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_vld_q   <= rx_vld_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            miso_s1_q  <= spi_miso;
            miso_s2_q  <= miso_s1_q;
            samp_q     <= samp_d;
        end
    end

    assign tx_ready      = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign spi_cs        = cs_q;
    assign spi_mosi      = mosi_q;
    assign rx_data       = rx_data_q;
    assign rx_data_valid = rx_vld_q;

endmodule
